// File: rtl/pipeline_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
package pipeline_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [1:0] RES_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;
  localparam logic [1:0] FWD_LUI = 2'b11;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);
  logic [CNT_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)                    q_d = '0;
    else if (inc && q_q != '1)  q_d = q_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stateful hazard controller: load-use, jump flush, M/W forwarding, MUL/DIV and
// data-memory hold sequencing, plus saturating stall/flush/load-use counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic [REG_AW-1:0] rs1_E,
  input  logic [REG_AW-1:0] rs2_E,
  input  logic [REG_AW-1:0] rd_E,
  input  logic [REG_AW-1:0] rd_M,
  input  logic [REG_AW-1:0] rd_W,
  input  logic              reg_wr_M,
  input  logic              reg_wr_W,
  input  logic [1:0]        res_src_E,
  input  logic [6:0]        op_E,
  input  logic              jump_E,
  input  logic              md_start_E,
  input  logic              md_done,
  input  logic              mem_req_M,
  input  logic              mem_ready,
  input  logic              cnt_clr,
  output logic              stall_F,
  output logic              stall_D,
  output logic              stall_E,
  output logic              stall_M,
  output logic              flush_D,
  output logic              flush_E,
  output logic              flush_M,
  output logic              flush_W,
  output logic [1:0]        forwardA_src,
  output logic [1:0]        forwardB_src,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  lu_cnt
);
  state_e state_q, state_d;
  logic   mem_hold, md_hold, load_use;
  logic   hold_m, hold_e, lu_stall, jump_take;

  assign mem_hold = mem_req_M & ~mem_ready;
  assign md_hold  = md_start_E & ~md_done;
  assign load_use = (res_src_E == RES_LOAD) && (rd_E != '0) &&
                    ((rd_E == rs1_D) || (rd_E == rs2_D));

  // hold_m: freeze F..M and bubble W; hold_e: freeze F..E and bubble M.
  always_comb begin
    state_d  = state_q;
    hold_m   = 1'b0;
    hold_e   = 1'b0;
    lu_stall = 1'b0;
    if (!rst_n) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_hold)      begin hold_m = 1'b1; state_d = MEM_WAIT; end
          else if (md_hold)  begin hold_e = 1'b1; state_d = MD_WAIT;  end
          else if (load_use) lu_stall = 1'b1;
        end
        MD_WAIT: begin
          if (mem_hold)      begin hold_m = 1'b1; state_d = MEM_WAIT; end
          else if (!md_done) hold_e = 1'b1;
          else               state_d = RUN;
        end
        MEM_WAIT: begin
          if (!mem_ready) hold_m = 1'b1;
          else            state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign stall_F = hold_m | hold_e | lu_stall;
  assign stall_D = stall_F;
  assign stall_E = hold_m | hold_e;
  assign stall_M = hold_m;
  assign flush_W = hold_m;
  assign flush_M = hold_e;

  // A held E instruction cannot redirect; load-use outranks the jump in RUN.
  assign jump_take = rst_n & jump_E & ~stall_E & ~lu_stall;
  assign flush_D   = ~rst_n | jump_take;
  assign flush_E   = ~rst_n | jump_take | lu_stall;
  assign md_busy   = rst_n & (state_q == MD_WAIT);

  logic a_m, a_w, b_m, b_w;
  assign a_m = reg_wr_M && (rs1_E == rd_M) && (rs1_E != '0);
  assign a_w = reg_wr_W && (rs1_E == rd_W) && (rs1_E != '0);
  assign b_m = reg_wr_M && (rs2_E == rd_M) && (rs2_E != '0);
  assign b_w = reg_wr_W && (rs2_E == rd_W) && (rs2_E != '0);

  assign forwardA_src = (op_E == OP_LUI) ? FWD_LUI :
                        a_m ? FWD_M : a_w ? FWD_W : FWD_RF;
  assign forwardB_src = b_m ? FWD_M : b_w ? FWD_W : FWD_RF;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(stall_F),  .q(stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(flush_D),  .q(flush_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(lu_stall), .q(lu_cnt));
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios plus random traffic against a hold-level reference model.
module tb_pipeline_hazard_ctrl;
  localparam int AW   = 5;
  localparam int CW   = 8;  // narrow counters so saturation is reachable quickly
  localparam logic [CW-1:0] CMAX = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic          reg_wr_M, reg_wr_W;
  logic [1:0]    res_src_E;
  logic [6:0]    op_E;
  logic          jump_E, md_start_E, md_done, mem_req_M, mem_ready, cnt_clr;
  logic          stall_F, stall_D, stall_E, stall_M;
  logic          flush_D, flush_E, flush_M, flush_W;
  logic [1:0]    forwardA_src, forwardB_src;
  logic          md_busy;
  logic [CW-1:0] stall_cnt, flush_cnt, lu_cnt;

  pipeline_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .reg_wr_M(reg_wr_M), .reg_wr_W(reg_wr_W),
    .res_src_E(res_src_E), .op_E(op_E), .jump_E(jump_E),
    .md_start_E(md_start_E), .md_done(md_done),
    .mem_req_M(mem_req_M), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
    .forwardA_src(forwardA_src), .forwardB_src(forwardB_src),
    .md_busy(md_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .lu_cnt(lu_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: mode 0 = running, 1 = waiting on MUL/DIV, 2 = waiting on memory.
  int            mode = 0;
  logic [CW-1:0] m_stall = '0, m_flush = '0, m_lu = '0;

  function automatic logic [1:0] fwd(input logic [AW-1:0] rs, input bit lui);
    if (lui)                                  return 2'd3;
    if (rs != 0 && reg_wr_M && rs == rd_M)    return 2'd2;
    if (rs != 0 && reg_wr_W && rs == rd_W)    return 2'd1;
    return 2'd0;
  endfunction

  task automatic idle();
    rst_n = 1'b1; cnt_clr = 1'b0;
    rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0;
    rd_E = '0; rd_M = '0; rd_W = '0;
    reg_wr_M = 1'b0; reg_wr_W = 1'b0; res_src_E = 2'b00; op_E = 7'b0110011;
    jump_E = 1'b0; md_start_E = 1'b0; md_done = 1'b0;
    mem_req_M = 1'b0; mem_ready = 1'b1;
  endtask

  // One clock: predict outputs, compare mid-cycle, then advance model at the edge.
  task automatic step(input string tag);
    int lvl, nmode;
    bit lu, jmp, fd, fe;
    logic [12:0] e, g;
    lu    = (res_src_E == 2'b01) && (rd_E != 0) && (rd_E == rs1_D || rd_E == rs2_D);
    lvl   = 0;   // 0 free, 1 load-use, 2 E held, 3 M held
    nmode = mode;
    if (!rst_n)                          nmode = 0;
    else if (mode == 2) begin
      if (!mem_ready) lvl = 3; else nmode = 0;
    end else if (mem_req_M && !mem_ready) begin
      lvl = 3; nmode = 2;
    end else if (mode == 1) begin
      if (!md_done) lvl = 2; else nmode = 0;
    end else if (md_start_E && !md_done) begin
      lvl = 2; nmode = 1;
    end else if (lu) lvl = 1;
    jmp = rst_n && jump_E && lvl == 0;
    fd  = !rst_n || jmp;
    fe  = !rst_n || jmp || lvl == 1;
    e = {lvl >= 1, lvl >= 1, lvl >= 2, lvl == 3, fd, fe, lvl == 2, lvl == 3,
         fwd(rs1_E, op_E == 7'b0110111), fwd(rs2_E, 1'b0), rst_n && mode == 1};
    #2;
    g = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W,
         forwardA_src, forwardB_src, md_busy};
    chk({tag, ":out"}, {51'd0, g}, {51'd0, e});
    @(posedge clk);
    if (!rst_n || cnt_clr) begin
      m_stall = '0; m_flush = '0; m_lu = '0;
    end else begin
      if (lvl >= 1 && m_stall != CMAX) m_stall = m_stall + 1'b1;
      if (fd && m_flush != CMAX)       m_flush = m_flush + 1'b1;
      if (lvl == 1 && m_lu != CMAX)    m_lu = m_lu + 1'b1;
    end
    mode = nmode;
    #1;
    chk({tag, ":cnt"}, {40'd0, stall_cnt, flush_cnt, lu_cnt}, {40'd0, m_stall, m_flush, m_lu});
  endtask

  task automatic clear_cnt();
    idle(); cnt_clr = 1'b1; step("clr"); cnt_clr = 1'b0;
  endtask

  initial begin
    idle();
    #1;
    rst_n = 1'b0; jump_E = 1'b1;
    step("reset0"); step("reset1");
    chk("reset_flushD", {63'd0, flush_D}, 64'd1);
    idle();
    step("post_reset");

    // Load-use: exactly one stall cycle.
    clear_cnt();
    res_src_E = 2'b01; rd_E = 5'd5; rs2_D = 5'd5;
    step("lu");
    idle(); step("lu_after");
    chk("lu_cnt_1", {56'd0, lu_cnt}, 64'd1);

    // Forwarding priority and special cases.
    rs1_E = 5'd7; rd_M = 5'd7; rd_W = 5'd7; reg_wr_M = 1'b1; reg_wr_W = 1'b1;
    #1; chk("fwdA_M", {62'd0, forwardA_src}, 64'd2);
    step("fwd_m");
    rs1_E = 5'd0; step("fwd_x0");
    op_E = 7'b0110111; #1; chk("fwdA_lui", {62'd0, forwardA_src}, 64'd3);
    step("fwd_lui");
    idle();

    // MUL/DIV hold for 4 cycles.
    clear_cnt();
    md_start_E = 1'b1;
    for (int i = 0; i < 4; i++) step("md_wait");
    md_done = 1'b1; step("md_release");
    idle(); step("md_after");
    chk("md_stall_cnt_4", {56'd0, stall_cnt}, 64'd4);

    // Memory hold with a jump waiting in E.
    clear_cnt();
    mem_req_M = 1'b1; mem_ready = 1'b0; jump_E = 1'b1;
    for (int i = 0; i < 3; i++) step("mem_wait");
    mem_ready = 1'b1; step("mem_release");
    idle(); step("mem_after");
    chk("mem_flush_cnt_1", {56'd0, flush_cnt}, 64'd1);

    // MEM stall arising during MUL/DIV wait.
    md_start_E = 1'b1;
    step("md2_a"); step("md2_b");
    mem_req_M = 1'b1; mem_ready = 1'b0;
    step("md2mem_a"); step("md2mem_b");
    md_start_E = 1'b0; mem_ready = 1'b1; step("md2mem_rel");
    idle(); step("md2mem_run");

    // Reset aborts MUL/DIV wait.
    md_start_E = 1'b1;
    step("rst_md_a"); step("rst_md_b");
    rst_n = 1'b0; step("rst_md_hit");
    idle(); step("rst_md_after");
    chk("rst_md_busy", {63'd0, md_busy}, 64'd0);

    // Saturation of stall_cnt.
    clear_cnt();
    mem_req_M = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < int'(CMAX) + 6; i++) step("sat");
    chk("sat_stall_cnt", {56'd0, stall_cnt}, {56'd0, CMAX});
    mem_ready = 1'b1; step("sat_rel");
    idle(); step("sat_after");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 63) != 0);
      cnt_clr    = ($urandom_range(0, 31) == 0);
      rs1_D      = 5'($urandom_range(0, 3));
      rs2_D      = 5'($urandom_range(0, 3));
      rs1_E      = 5'($urandom_range(0, 3));
      rs2_E      = 5'($urandom_range(0, 3));
      rd_E       = 5'($urandom_range(0, 3));
      rd_M       = 5'($urandom_range(0, 3));
      rd_W       = 5'($urandom_range(0, 3));
      reg_wr_M   = 1'($urandom_range(0, 1));
      reg_wr_W   = 1'($urandom_range(0, 1));
      res_src_E  = 2'($urandom_range(0, 3));
      op_E       = ($urandom_range(0, 7) == 0) ? 7'b0110111 : 7'($urandom);
      jump_E     = ($urandom_range(0, 3) == 0);
      md_start_E = ($urandom_range(0, 3) == 0);
      md_done    = ($urandom_range(0, 2) == 0);
      mem_req_M  = ($urandom_range(0, 3) == 0);
      mem_ready  = ($urandom_range(0, 1) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard and forwarding controller for the five-stage RISC-V core. It replaces the purely combinational hazard unit with a stateful controller. On top of load-use stalls, jump flushes and M/W forwarding, it adds two things: hold sequencing for a variable-latency MUL/DIV unit in E, and hold sequencing for a data memory with a ready handshake in M. It also keeps saturating stall/flush performance counters. It sits beside the pipeline registers and drives their enable/clear inputs and the E-stage operand muxes.

## Interface
- REG_AW, 5, register-index width
- CNT_W, 16, performance-counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W  in  REG_AW  source/destination indices per stage
- reg_wr_M, reg_wr_W  in  1  register write enables in M/W
- res_src_E  in  2  result source of E instruction; 2'b01 = load
- op_E  in  7  opcode in E; 7'b0110111 = LUI
- jump_E  in  1  taken jump/branch resolved in E
- md_start_E  in  1  MUL/DIV instruction present in E
- md_done  in  1  MUL/DIV result valid (single-cycle pulse)
- mem_req_M  in  1  load/store in M
- mem_ready  in  1  data memory completes the access this cycle
- cnt_clr  in  1  synchronous clear of all counters
- stall_F, stall_D, stall_E, stall_M  out  1  hold the corresponding pipeline register
- flush_D, flush_E, flush_M, flush_W  out  1  insert a bubble into the corresponding register
- forwardA_src, forwardB_src  out  2  00 regfile, 01 W, 10 M, 11 LUI zero (A only)
- md_busy  out  1  state == MD_WAIT
- stall_cnt, flush_cnt, lu_cnt  out  CNT_W  stall cycles, flush events, load-use stalls

## Operation
- Three states, priority in this order: MEM_WAIT, MD_WAIT, RUN.
- RUN:
  - If mem_req_M & !mem_ready: assert stall_F/D/E/M and flush_W; go to MEM_WAIT.
  - Else if md_start_E & !md_done: assert stall_F/D/E and flush_M; go to MD_WAIT.
  - Else if load-use: assert stall_F/D and flush_E; stay in RUN. Load-use means res_src_E==01, rd_E!=0, and rd_E equals rs1_D or rs2_D.
  - Else if jump_E: assert flush_D and flush_E.
- MEM_WAIT:
  - While mem_ready==0: assert stall_F/D/E/M and flush_W.
  - In the cycle mem_ready==1: drop all stalls and go to RUN.
  - A pending md_start_E or load-use is evaluated from RUN on the next cycle.
- MD_WAIT:
  - While md_done==0: assert stall_F/D/E and flush_M.
  - In the cycle md_done==1: release all stalls and go to RUN.
  - A MEM_WAIT condition arising in M during MD_WAIT takes priority: add stall_M, replace flush_M with flush_W, and go to MEM_WAIT. E remains held.
- Jump suppression: jump_E is ignored in any cycle where stall_E is asserted. It takes effect on the release cycle.
- Forwarding is combinational in every state:
  - forwardA_src = 11 when op_E==LUI.
  - Otherwise 10 when rs1_E==rd_M & reg_wr_M & rs1_E!=0.
  - Otherwise 01 on the same test against rd_W/reg_wr_W.
  - Otherwise 00.
  - B uses the same rules without the LUI case. M beats W on a double match.
- Counters:
  - stall_cnt increments on every cycle with stall_F==1.
  - flush_cnt increments on every cycle with flush_D==1.
  - lu_cnt increments on every load-use stall cycle.
  - All counters saturate at 2^CNT_W−1.
  - cnt_clr zeroes them; clear wins over increment in the same cycle.

## Timing
- Stall/flush/forward outputs are combinational from the current state and inputs; no added latency.
- State and counters update on the rising edge of clk.
- While rst_n==0:
  - state is forced to RUN and all counters go to 0.
  - All stalls, flush_M, flush_W and md_busy are 0.
  - flush_D=flush_E=1, so the pipeline fills with bubbles.
  - forward*_src follows the normal rules.
- Reset asserted mid-MD_WAIT or mid-MEM_WAIT aborts the wait and releases the stalls in the same cycle. The next state after reset is RUN.
- md_done is honoured in RUN: md_start_E & md_done in the same cycle causes no stall.
- Minimum MD_WAIT or MEM_WAIT residency is one cycle.

## Structure
- Shared package pipeline_pkg:
  - state enum {RUN, MD_WAIT, MEM_WAIT}
  - constants OP_LUI=7'b0110111, RES_LOAD=2'b01
  - FWD_RF/FWD_W/FWD_M/FWD_LUI encodings
- Sub-module sat_counter (params CNT_W; ports clk, rst_n, clr, inc, q), instantiated three times.

## Test plan
- Load x5 in E (res_src_E=01, rd_E=5), rs2_D=5 → exactly 1 cycle of stall_F=stall_D=flush_E=1; lu_cnt=1.
- rs1_E=7, rd_M=7, rd_W=7, both reg_wr=1 → forwardA_src=10. With rs1_E=0 → 00. With op_E=LUI → 11.
- md_start_E=1, md_done after 4 cycles → md_busy=1 and stall_F/D/E=1 for 4 cycles; released in the md_done cycle; stall_cnt=4.
- mem_req_M=1, mem_ready=0 for 3 cycles, while jump_E=1 throughout → stall_F/D/E/M and flush_W for 3 cycles, no flush_D. flush_D/E=1 in the release cycle; flush_cnt=1.
- MD_WAIT for 2 cycles, then mem_ready drops for 2 cycles → MEM_WAIT with stall_M=1, then return to RUN.
- rst_n=0 during MD_WAIT → stalls 0, flush_D/E=1, counters 0; RUN after release. Preload stall_cnt to saturation → it holds at 0xFFFF.
